// File: rtl/spi_tx_sequencer.sv
// spi_tx_sequencer: byte FIFO plus frame sequencer that drives an SPI master's strt/data_in and holds the SPI mode
module spi_tx_sequencer #(
  parameter int DEPTH       = 4,
  parameter int STRT_CYCLES = 2,
  parameter int GAP_CYCLES  = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     cfg_we,
  input  logic                     cfg_cph,
  input  logic                     cfg_ckp,
  input  logic                     err_clr,
  input  logic                     CS,
  output logic [7:0]               data_in,
  output logic                     strt,
  output logic                     CPH,
  output logic                     CKP,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic [7:0]               frames_done,
  output logic                     ovf_err,
  output logic                     to_err
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CNW = AW + 1;
  localparam int MX  = TIMEOUT > STRT_CYCLES ? (TIMEOUT > GAP_CYCLES ? TIMEOUT : GAP_CYCLES)
                                             : (STRT_CYCLES > GAP_CYCLES ? STRT_CYCLES : GAP_CYCLES);
  localparam int CW  = $clog2(MX) + 1;
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD      = 3'd1;
  localparam logic [2:0] START     = 3'd2;
  localparam logic [2:0] WAIT_LOW  = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;
  localparam logic [2:0] GAP       = 3'd5;
  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CNW-1:0] count_nx;
  logic [2:0]     state, state_nx;
  logic [CW-1:0]  cnt, lim;
  logic           last, pop, push, ovf_ev, to_ev;
  // one shared cycle counter; its terminal value depends on which timed state we are in
  assign lim      = state == START ? CW'(STRT_CYCLES - 1) : state == WAIT_LOW ? CW'(TIMEOUT - 1) : CW'(GAP_CYCLES - 1);
  assign last     = cnt == lim;
  assign pop      = state == IDLE && count != '0;
  assign push     = wr_en && !full;
  assign ovf_ev   = wr_en && full;
  assign to_ev    = state == WAIT_LOW && CS && last;
  assign count_nx = count + CNW'(push) - CNW'(pop);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = pop ? LOAD : IDLE;
      LOAD:      state_nx = START;
      START:     state_nx = last ? WAIT_LOW : START;
      WAIT_LOW:  state_nx = !CS ? WAIT_HIGH : last ? GAP : WAIT_LOW;
      WAIT_HIGH: state_nx = CS ? GAP : WAIT_HIGH;
      GAP:       state_nx = last ? IDLE : GAP;
      default:   state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      data_in     <= '0;
      strt        <= 1'b0;
      CPH         <= 1'b0;
      CKP         <= 1'b1;
      busy        <= 1'b0;
      frames_done <= '0;
      ovf_err     <= 1'b0;
      to_err      <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= state_nx != state ? '0 : cnt + CW'(1);
      count   <= count_nx;
      full    <= count_nx == CNW'(DEPTH);
      empty   <= count_nx == '0;
      strt    <= state_nx == START;
      busy    <= state_nx != IDLE;
      ovf_err <= ovf_ev | (ovf_err & ~err_clr);
      to_err  <= to_ev | (to_err & ~err_clr);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        data_in <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + AW'(1);
      end
      if (state == WAIT_HIGH && CS) frames_done <= frames_done + 8'd1;
      // mode only moves when no frame is running or pending
      if (cfg_we && state == IDLE && empty) begin
        CPH <= cfg_cph;
        CKP <= cfg_ckp;
      end
    end
  end
endmodule

// File: tb/tb_spi_tx_sequencer.sv
// tb_spi_tx_sequencer: timeline model of the sequencer plus directed scenarios with a looped-back CS
module tb_spi_tx_sequencer;
  localparam int DEPTH = 4, S = 2, G = 4, T = 64, CS_LEN = 10;
  logic clk = 0, rst = 1, wr_en = 0, cfg_we = 0, cfg_cph = 0, cfg_ckp = 0, err_clr = 0, cs = 1;
  logic [7:0] wr_data = 0;
  logic [7:0] data_in, frames_done;
  logic strt, cph, ckp, full, empty, busy, ovf_err, to_err;
  logic [2:0] count;
  int checks = 0, passed = 0;
  spi_tx_sequencer #(.DEPTH(DEPTH), .STRT_CYCLES(S), .GAP_CYCLES(G), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .cfg_we(cfg_we), .cfg_cph(cfg_cph),
    .cfg_ckp(cfg_ckp), .err_clr(err_clr), .CS(cs), .data_in(data_in), .strt(strt), .CPH(cph),
    .CKP(ckp), .full(full), .empty(empty), .count(count), .busy(busy), .frames_done(frames_done),
    .ovf_err(ovf_err), .to_err(to_err));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask
  // model: a frame is described by the edge p that popped it, the edge tl where CS was seen low,
  // and the edge tg where the gap began; everything else follows from those timestamps
  logic [7:0] q[$];
  logic [7:0] m_data = 0, m_fr = 0;
  int n = 0, p = 0, tl = -1, tg = -1, sz = 0, cs_rise = -1;
  bit act = 0, mv = 0, m_ovf = 0, m_to = 0, m_cph = 0, m_ckp = 1, seto = 0, pcs = 1, pst = 0;
  always @(posedge clk) begin
    n++;
    if (rst) begin
      q.delete();
      act = 0; m_data = 0; m_fr = 0; m_ovf = 0; m_to = 0; m_cph = 0; m_ckp = 1; mv = 1; cs_rise = -1;
    end else begin
      sz = q.size();
      seto = 0;
      m_ovf = (wr_en && sz == DEPTH) || (m_ovf && !err_clr);
      if (cfg_we && !act && sz == 0) begin m_cph = cfg_cph; m_ckp = cfg_ckp; end
      if (!act) begin
        if (sz > 0) begin m_data = q.pop_front(); act = 1; p = n; tl = -1; tg = -1; end
      end else if (tg >= 0) begin
        if (n == tg + G) act = 0;
      end else if (tl >= 0) begin
        if (cs) begin m_fr++; tg = n; end
      end else if (n > p + 1 + S) begin
        if (!cs) tl = n;
        else if (n == p + 1 + S + T) begin seto = 1; tg = n; end
      end
      m_to = seto || (m_to && !err_clr);
      if (wr_en && sz < DEPTH) q.push_back(wr_data);
      if (cs && !pcs) cs_rise = n;
    end
    pcs = cs;
  end
  always @(negedge clk) if (mv) begin
    chk("data_in", data_in, m_data);
    chk("strt", strt, act && n >= p + 1 && n < p + 1 + S);
    chk("busy", busy, act);
    chk("count", count, q.size());
    chk("full", full, q.size() == DEPTH);
    chk("empty", empty, q.size() == 0);
    chk("frames_done", frames_done, m_fr);
    chk("ovf_err", ovf_err, m_ovf);
    chk("to_err", to_err, m_to);
    chk("CPH", cph, m_cph);
    chk("CKP", ckp, m_ckp);
    if (strt && !pst && cs_rise >= 0) chk("strt spacing after CS rise", n - cs_rise >= G + 2, 1);
    pst = strt;
  end
  // master stand-in: mode 0 loops CS low for CS_LEN cycles after strt falls, 1 holds low, 2 holds high
  int cs_mode = 2, cs_tmr = 0;
  logic ps = 0;
  always @(negedge clk) begin
    if (cs_mode == 1) cs = 0;
    else if (cs_mode == 2) cs = 1;
    else if (cs_tmr > 0) begin cs_tmr--; cs = cs_tmr == 0; end
    else if (ps && !strt) begin cs = 0; cs_tmr = CS_LEN; end
    else cs = 1;
    ps = strt;
  end
  function automatic int sig(input int w);
    case (w)
      0: return int'(strt);
      1: return int'(busy);
      2: return int'(to_err);
      default: return int'(!busy && empty);
    endcase
  endfunction
  task automatic tick(input int k = 1);
    repeat (k) @(negedge clk);
  endtask
  task automatic wait_sig(input string name, input int w, input int v, output int k);
    k = 0;
    while (sig(w) != v && k < 500) begin @(negedge clk); k++; end
    if (k >= 500) begin
      checks++;
      $display("FAIL %s: timed out after %0d cycles waiting for %0d", name, k, v);
    end
  endtask
  task automatic push(input logic [7:0] d);
    wr_en = 1; wr_data = d;
    tick();
    wr_en = 0;
  endtask
  task automatic do_reset(input int mode);
    rst = 1; cs_mode = 2;
    tick(2);
    rst = 0; cs_mode = mode;
    tick();
  endtask
  task automatic set_mode(input logic c, input logic k);
    cfg_we = 1; cfg_cph = c; cfg_ckp = k;
    tick();
    cfg_we = 0;
  endtask
  int k;
  logic [7:0] exp_b [3] = '{8'h55, 8'h0F, 8'hA3};
  initial begin
    tick(2);
    chk("reset CKP", ckp, 1);
    chk("reset empty", empty, 1);
    do_reset(0);
    // single frame, mode CPH=1 CKP=0
    set_mode(1, 0);
    chk("mode10 CPH", cph, 1);
    chk("mode10 CKP", ckp, 0);
    push(8'h55);
    wait_sig("first strt", 0, 1, k);
    chk("data_in at strt", data_in, 8'h55);
    k = 0;
    while (strt && k < 10) begin tick(); k++; end
    chk("strt width", k, 2);
    wait_sig("frame1 idle", 3, 1, k);
    chk("frames after 1", frames_done, 1);
    chk("busy after 1", busy, 0);
    // three back-to-back bytes
    do_reset(0);
    push(8'h55); push(8'h0F); push(8'hA3);
    for (int i = 0; i < 3; i++) begin
      wait_sig("b2b strt", 0, 1, k);
      chk("b2b byte order", data_in, exp_b[i]);
      wait_sig("b2b strt low", 0, 0, k);
    end
    wait_sig("b2b idle", 3, 1, k);
    chk("frames after 3", frames_done, 3);
    chk("empty after 3", empty, 1);
    // overflow with the master stalled
    do_reset(1);
    push(8'h01);
    tick(6);
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    chk("ovf full", full, 1);
    chk("ovf count", count, 4);
    chk("ovf flag", ovf_err, 1);
    err_clr = 1; tick(); err_clr = 0;
    chk("ovf cleared", ovf_err, 0);
    cs_mode = 0;
    wait_sig("ovf drain", 3, 1, k);
    chk("frames after drain", frames_done, 5);
    // CS timeout
    do_reset(2);
    push(8'h12);
    wait_sig("to strt", 0, 1, k);
    wait_sig("to strt low", 0, 0, k);
    wait_sig("to flag", 2, 1, k);
    chk("timeout latency", k, 64);
    chk("timeout frames", frames_done, 0);
    wait_sig("to idle", 3, 1, k);
    cs_mode = 0;
    push(8'h34);
    wait_sig("after to idle", 3, 1, k);
    chk("frames after retry", frames_done, 1);
    chk("to sticky", to_err, 1);
    err_clr = 1; tick(); err_clr = 0;
    chk("to cleared", to_err, 0);
    // mode writes
    do_reset(0);
    push(8'h77);
    wait_sig("mode busy", 1, 1, k);
    set_mode(1, 0);
    chk("busy cfg CPH", cph, 0);
    chk("busy cfg CKP", ckp, 1);
    wait_sig("mode idle", 3, 1, k);
    set_mode(1, 0);
    chk("idle cfg CPH", cph, 1);
    chk("idle cfg CKP", ckp, 0);
    do_reset(0);
    chk("reset CPH", cph, 0);
    chk("reset CKP2", ckp, 1);
    // reset during WAIT_HIGH with two bytes queued
    do_reset(1);
    push(8'h21); push(8'h22); push(8'h23);
    tick(6);
    chk("queued before rst", count, 2);
    chk("busy before rst", busy, 1);
    rst = 1;
    tick();
    chk("rst count", count, 0);
    chk("rst strt", strt, 0);
    chk("rst busy", busy, 0);
    chk("rst frames", frames_done, 0);
    cs_mode = 2; rst = 0;
    tick(3);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, checks);
    $fatal(1);
  end
endmodule
